fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage for the rv32i core: the producer end of the instruction path whose consumer is the control unit. It owns the PC, issues word reads to instruction memory over a valid/ready request channel, accepts in-order responses, and buffers up to two fetched instructions. Each instruction is presented with its PC and pre-split `op`/`f3`/`f7` fields wired straight into the control unit. A redirect input, driven from branch/jump resolution, flushes the buffer and discards stale in-flight responses.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `DEPTH`, default 2: instruction buffer entries, which is also the outstanding-plus-buffered credit limit.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `imem_req_valid`  out  1  read request valid.
- `imem_req_ready`  in  1  memory accepts the request this cycle.
- `imem_req_addr`  out  32  word address (PC); bits [1:0] are always 0.
- `imem_rsp_valid`  in  1  response data valid. Responses are in order, latency ≥1 cycle, and cannot be stalled.
- `imem_rsp_data`  in  32  instruction word.
- `redirect`  in  1  taken branch/jump; single-cycle pulse.
- `redirect_pc`  in  32  new PC; bits [1:0] are forced to 0.
- `inst_valid`  out  1  buffered instruction available.
- `inst_ready`  in  1  decode consumes the instruction this cycle.
- `inst`  out  32  instruction word; reads NOP 32'h0000_0013 whenever `inst_valid`=0.
- `inst_pc`  out  32  PC of `inst`.
- `op`  out  7  `inst[6:0]`.
- `f3`  out  3  `inst[14:12]`.
- `f7`  out  1  `inst[30]`.

## Operation
- **State:** `pc`, `outstanding` (0..DEPTH), `drop` (0..DEPTH), 2-entry FIFO of {word, pc}.
- **Issue rule:** `imem_req_valid` = !rst_state && (outstanding + fifo_count < DEPTH).
  - `imem_req_addr` = `pc`.
  - On req handshake: `pc` += 4 and `outstanding`++.
- **Response when `drop`>0:** `drop`-- and `outstanding`--. Data is discarded.
- **Response when `drop`=0:** push {data, pc_of_request} and `outstanding`--. A small in-order PC queue (DEPTH entries) tracks request PCs.
- **Consume:** pop when `inst_valid` && `inst_ready`.
- **Redirect:**
  - `pc` ← `redirect_pc` & ~3.
  - FIFO and PC queue flushed.
  - `drop` ← number of requests still in flight after this cycle. This counts a request handshaking in the same cycle and excludes a response arriving in the same cycle.
  - A same-cycle response is discarded.
  - A same-cycle request targets the old PC and is counted in `drop`.
  - A same-cycle pop is ignored.
- **Overflow:** the credit rule guarantees the FIFO never overflows. An overflow is an assertion failure.
- **Reset values:**
  - `pc`=RESET_PC; counts 0; FIFO empty.
  - `imem_req_valid`=0, `inst_valid`=0, `inst`=32'h0000_0013, `inst_pc`=0.
  - `op`=7'h13, `f3`=0, `f7`=0.
- **Reset mid-operation:** all state clears immediately. Responses to pre-reset requests must not arrive afterwards; the memory is reset by the same `rst`.

## Timing
- First request is asserted in the first cycle after `rst` deasserts, with address RESET_PC.
- A request accepted in cycle N with response in cycle N+L gives `inst_valid` in cycle N+L+1. The FIFO output is registered; there is no response-to-output bypass.
- With L=1, `imem_req_ready`=1 and `inst_ready`=1, throughput is one instruction per cycle in steady state (DEPTH=2).
- Redirect in cycle N:
  - `inst_valid`=0 in N+1.
  - Request to `redirect_pc` in N+1.
  - First new instruction no earlier than N+3 with L=1.
- `op`/`f3`/`f7` are combinational slices of `inst`, so they are stable for the whole cycle.

## Structure
- Package `rv32i_pkg`:
  - `NOP_INST` = 32'h0000_0013.
  - `XLEN` = 32.
  - `PC_STEP` = 4.
  - Opcode field width constants shared with the control unit.
- Sub-module `inst_fifo`: parameterised DEPTH, synchronous push/pop/flush, count output, asynchronous active-high reset. It is instantiated twice, once for instructions+PC and once as the in-flight PC queue.

## Test plan
1. **Reset and streaming:** release reset with L=1 and memory returning `addr`.
   - `imem_req_addr` 0,4,8,…
   - `inst`/`inst_pc` pairs (0,0),(4,4),… at 1/cycle from cycle 3.
2. **Backpressure:** hold `inst_ready`=0 for 10 cycles.
   - Exactly 2 requests issued, then `imem_req_valid`=0.
   - On release, `inst_pc` 0,4,8 in order with no loss.
3. **Redirect with 2 in flight:** L=3; redirect to 0x100 while responses for 0x8 and 0xC are pending.
   - Both responses dropped.
   - Next `inst_pc`=0x100.
4. **Same-cycle events:** redirect to 0x203 coincides with a response and a request handshake.
   - Response discarded.
   - `imem_req_addr`=0x200 the next cycle.
   - Old request dropped.
5. **Memory stall:** `imem_req_ready`=0 for 5 cycles.
   - `imem_req_addr` held stable.
   - `inst_valid`=0 and `inst`=0x00000013 with `op`=7'h13.
6. **Mid-run reset:** assert `rst` asynchronously mid-stream.
   - Outputs at reset values within the same cycle.
   - Restart at RESET_PC.

Source files
------------

// File: rtl/rv32i_pkg.sv
// rv32i_pkg: constants and types shared by the fetch unit and the control unit.
package rv32i_pkg;
    localparam int XLEN = 32;
    localparam int PC_STEP = 4;
    localparam int OP_W = 7;
    localparam int F3_W = 3;
    localparam int F7_W = 1;
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] word;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;
endpackage

// File: rtl/inst_fifo.sv
// inst_fifo: small FIFO with synchronous push/pop/flush and an occupancy count.
module inst_fifo #(
    parameter int W = 32,
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count
);
    logic [W-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic do_push, do_pop;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        do_pop = pop && !flush && (cnt_q != '0);
        do_push = push && !flush && ((cnt_q != CW'(DEPTH)) || do_pop);
        wr_d = flush ? '0 : (do_push ? inc(wr_q) : wr_q);
        rd_d = flush ? '0 : (do_pop ? inc(rd_q) : rd_q);
        cnt_d = flush ? '0 : cnt_q + CW'(do_push) - CW'(do_pop);
        dout = mem_q[rd_q];
        count = cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
            cnt_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end

    // A push into a full FIFO without a pop means the producer broke its credit limit.
    always @(posedge clk) begin
        if (!rst && !flush) assert (!(push && !pop && cnt_q == CW'(DEPTH)));
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: rv32i instruction fetch; owns the PC, issues imem reads, buffers
// returned words and discards responses made stale by a redirect.
module fetch_unit
    import rv32i_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic [OP_W-1:0] op,
    output logic [F3_W-1:0] f3,
    output logic [F7_W-1:0] f7
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0] out_q, out_d, drop_q, drop_d;
    logic [CW-1:0] fifo_cnt, pcq_cnt;
    logic [CW:0] used;
    fetch_entry_t fifo_din, fifo_dout;
    logic [XLEN-1:0] pcq_dout;
    logic pop, req_fire, rsp_keep;

    always_comb begin
        inst_valid = (fifo_cnt != '0);
        pop = inst_valid && inst_ready;
        // The slot being consumed this cycle is already free for a new request.
        used = (CW+1)'(out_q) + (CW+1)'(fifo_cnt) - (CW+1)'(pop);
        imem_req_valid = !rst && (used < (CW+1)'(DEPTH));
        imem_req_addr = pc_q;
        req_fire = imem_req_valid && imem_req_ready;
        rsp_keep = imem_rsp_valid && (drop_q == '0) && !redirect;
        fifo_din = {imem_rsp_data, pcq_dout};
        pc_d = redirect ? (redirect_pc & ~XLEN'(3)) : (req_fire ? pc_q + XLEN'(PC_STEP) : pc_q);
        out_d = out_q + CW'(req_fire) - CW'(imem_rsp_valid);
        drop_d = redirect ? out_d : drop_q - CW'(imem_rsp_valid && (drop_q != '0));
        inst = inst_valid ? fifo_dout.word : NOP_INST;
        inst_pc = inst_valid ? fifo_dout.pc : '0;
        op = inst[6:0];
        f3 = inst[14:12];
        f7 = inst[30];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
            out_q <= '0;
            drop_q <= '0;
        end else begin
            pc_q <= pc_d;
            out_q <= out_d;
            drop_q <= drop_d;
        end
    end

    inst_fifo #(.W($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_inst_fifo (
        .clk(clk), .rst(rst), .push(rsp_keep), .pop(pop), .flush(redirect),
        .din(fifo_din), .dout(fifo_dout), .count(fifo_cnt)
    );

    // Request PCs of live (non-dropped) in-flight reads, oldest first.
    inst_fifo #(.W(XLEN), .DEPTH(DEPTH)) u_pc_queue (
        .clk(clk), .rst(rst), .push(req_fire && !redirect), .pop(rsp_keep), .flush(redirect),
        .din(pc_q), .dout(pcq_dout), .count(pcq_cnt)
    );

    always @(posedge clk) begin
        if (!rst && rsp_keep) assert (pcq_cnt != '0);
    end
endmodule
